// File: rtl/wfg_stim_burst_seq_if.sv
// ----------------------------------------------------------------------------
// wfg_stim_burst_seq_if
//   Stream bundle for the burst sequencer. It carries both the stimulus-side
//   AXI-Stream sink (s_*) and the driver-side AXI-Stream source (m_*).
//   Signal suffixes are written from the sequencer's point of view.
//
//   Modports
//     slave  : the sequencer itself (accepts s_*, produces m_*)
//     master : the environment around it (produces s_*, accepts m_*)
//
//   Signals
//     s_tvalid_i  stimulus valid          s_tready_o  stimulus ready
//     s_tdata_i   stimulus sample         m_tvalid_o  driver valid
//     m_tready_i  driver ready            m_tdata_o   driver sample
// ----------------------------------------------------------------------------
interface wfg_stim_burst_seq_if #(
  parameter int DATAW = 18
) ();

  logic             s_tvalid_i;
  logic             s_tready_o;
  logic [DATAW-1:0] s_tdata_i;
  logic             m_tvalid_o;
  logic             m_tready_i;
  logic [DATAW-1:0] m_tdata_o;

  modport slave (
    input  s_tvalid_i, s_tdata_i, m_tready_i,
    output s_tready_o, m_tvalid_o, m_tdata_o
  );

  modport master (
    output s_tvalid_i, s_tdata_i, m_tready_i,
    input  s_tready_o, m_tvalid_o, m_tdata_o
  );

endinterface

// File: rtl/wfg_stim_burst_seq.sv
// ----------------------------------------------------------------------------
// wfg_stim_burst_seq
//   Burst sequencer between a stimulus generator and the SPI driver stream
//   sink. Passes bursts of burst_len_i samples separated by gap_len_i idle
//   cycles, repeat_i times (0 = forever), then parks in DONE until the enable
//   is cleared. One registered output stage.
//
//   Optional feature macro: WFG_BURST_IRQ_EN adds done_irq_o, a one-cycle
//   pulse on the RUN->DONE transition.
//
//   Ports
//     wb_clk_i     clock
//     wb_rst_i     synchronous reset, active high
//     ctrl_en_i    sequencer enable (level)
//     burst_len_i  samples per burst, 0 = never start
//     gap_len_i    idle cycles between bursts, 0 = back-to-back
//     repeat_i     number of bursts, 0 = infinite
//     bus          stream bundle (slave modport): s_* in, m_* out
//     busy_o       high in RUN or GAP
//     burst_cnt_o  completed bursts (wraps in infinite mode)
//     done_irq_o   done pulse (only with WFG_BURST_IRQ_EN)
// ----------------------------------------------------------------------------
module wfg_stim_burst_seq #(
  parameter int DATAW = 18,
  parameter int CNTW  = 16
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     ctrl_en_i,
  input  logic [CNTW-1:0]          burst_len_i,
  input  logic [CNTW-1:0]          gap_len_i,
  input  logic [7:0]               repeat_i,
  wfg_stim_burst_seq_if.slave      bus,
  output logic                     busy_o,
  output logic [7:0]               burst_cnt_o
`ifdef WFG_BURST_IRQ_EN
  ,
  output logic                     done_irq_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam logic [CNTW-1:0] CNT_ONE = 1;

  state_e           state_q,     state_d;
  logic [CNTW-1:0]  len_q,       len_d;
  logic [CNTW-1:0]  gap_q,       gap_d;
  logic [7:0]       rep_q,       rep_d;
  logic [CNTW-1:0]  in_cnt_q,    in_cnt_d;
  logic [CNTW-1:0]  gap_cnt_q,   gap_cnt_d;
  logic [7:0]       burst_cnt_q, burst_cnt_d;
  logic             m_tvalid_q,  m_tvalid_d;
  logic [DATAW-1:0] m_tdata_q,   m_tdata_d;
`ifdef WFG_BURST_IRQ_EN
  logic             irq_q,       irq_d;
`endif

  // The output stage can take a new beat when it is empty or is being
  // drained by the sink in this very cycle.
  logic stage_free;
  logic s_tready;
  logic accept;
  logic last_burst;

  assign stage_free = !m_tvalid_q || bus.m_tready_i;
  assign s_tready   = (state_q == ST_RUN) && ctrl_en_i &&
                      (in_cnt_q < len_q) && stage_free;
  assign accept     = s_tready && bus.s_tvalid_i;
  // Compared in 8 bits, matching the width of the burst counter.
  assign last_burst = (rep_q != 8'd0) && ((burst_cnt_q + 8'd1) == rep_q);

  always_comb begin
    // NOTE: every next-state variable is given its hold value first so that
    // no branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    len_d       = len_q;
    gap_d       = gap_q;
    rep_d       = rep_q;
    in_cnt_d    = in_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    burst_cnt_d = burst_cnt_q;
    m_tvalid_d  = m_tvalid_q;
    m_tdata_d   = m_tdata_q;
`ifdef WFG_BURST_IRQ_EN
    irq_d       = 1'b0;
`endif

    // Output stage: a load wins over a drain, so valid is never withdrawn
    // and data only changes on a load.
    if (accept) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = bus.s_tdata_i;
    end else if (bus.m_tready_i) begin
      m_tvalid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_en_i && (burst_len_i != '0)) begin
          state_d     = ST_RUN;
          len_d       = burst_len_i;
          gap_d       = gap_len_i;
          rep_d       = repeat_i;
          in_cnt_d    = '0;
          gap_cnt_d   = '0;
          burst_cnt_d = '0;
        end
      end

      ST_RUN: begin
        if (accept) begin
          in_cnt_d = in_cnt_q + CNT_ONE;
        end
        if (!ctrl_en_i) begin
          // Abort: the pending beat drains first, the burst is not counted.
          if (stage_free) begin
            state_d  = ST_IDLE;
            in_cnt_d = '0;
          end
        end else if ((in_cnt_q == len_q) && stage_free) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
          in_cnt_d    = '0;
          if (last_burst) begin
            state_d = ST_DONE;
`ifdef WFG_BURST_IRQ_EN
            irq_d   = 1'b1;
`endif
          end else if (gap_q != '0) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end
        end
      end

      ST_GAP: begin
        if (!ctrl_en_i) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q == (gap_q - CNT_ONE)) begin
          state_d   = ST_RUN;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_ONE;
        end
      end

      ST_DONE: begin
        m_tvalid_d = 1'b0;
        if (!ctrl_en_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers update with non-blocking assignments so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      gap_q       <= '0;
      rep_q       <= '0;
      in_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      burst_cnt_q <= '0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
`ifdef WFG_BURST_IRQ_EN
      irq_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      rep_q       <= rep_d;
      in_cnt_q    <= in_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tdata_q   <= m_tdata_d;
`ifdef WFG_BURST_IRQ_EN
      irq_q       <= irq_d;
`endif
    end
  end

  assign bus.s_tready_o = s_tready;
  assign bus.m_tvalid_o = m_tvalid_q;
  assign bus.m_tdata_o  = m_tdata_q;
  assign busy_o         = (state_q == ST_RUN) || (state_q == ST_GAP);
  assign burst_cnt_o    = burst_cnt_q;
`ifdef WFG_BURST_IRQ_EN
  assign done_irq_o     = irq_q;
`endif

endmodule

// File: tb/tb_wfg_stim_burst_seq.sv
// ----------------------------------------------------------------------------
// tb_wfg_stim_burst_seq
//   Scoreboard bench for wfg_stim_burst_seq. A driver process plays a fixed
//   random sample table into the stimulus port and drives the sink ready.
//   For each scenario the model predicts, from the configuration alone, the
//   exact sample sequence the driver side must see and the final burst
//   count; a monitor pops and compares every delivered beat.
// ----------------------------------------------------------------------------
module tb_wfg_stim_burst_seq;

  localparam int DATAW = 18;
  localparam int CNTW  = 16;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_i;
  logic            ctrl_en_i;
  logic [CNTW-1:0] burst_len_i;
  logic [CNTW-1:0] gap_len_i;
  logic [7:0]      repeat_i;
  logic            busy_o;
  logic [7:0]      burst_cnt_o;
`ifdef WFG_BURST_IRQ_EN
  logic            done_irq_o;
`endif

  wfg_stim_burst_seq_if #(.DATAW(DATAW)) bus ();

  wfg_stim_burst_seq #(.DATAW(DATAW), .CNTW(CNTW)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .ctrl_en_i   (ctrl_en_i),
    .burst_len_i (burst_len_i),
    .gap_len_i   (gap_len_i),
    .repeat_i    (repeat_i),
    .bus         (bus),
    .busy_o      (busy_o),
    .burst_cnt_o (burst_cnt_o)
`ifdef WFG_BURST_IRQ_EN
    ,
    .done_irq_o  (done_irq_o)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks  = 0;
  int n_pass    = 0;
  int cyc       = 0;
  int m_cnt     = 0;
  int irq_cnt   = 0;
  int src_acc   = 0;
  int src_limit = 0;
  int snk_mode  = 1;   // 0 hold, 1 always ready, 2 random
  bit src_rand  = 1'b0;

  logic [DATAW-1:0] src_data [0:4095];
  logic [DATAW-1:0] exp_q [$];
  int               beat_cyc [$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  initial forever begin
    @(posedge wb_clk_i);
    cyc++;
  end

  // Source and sink driver.
  initial begin
    bit fire;
    bus.s_tvalid_i = 1'b0;
    bus.s_tdata_i  = '0;
    bus.m_tready_i = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      fire = bus.s_tvalid_i && bus.s_tready_o;
      @(posedge wb_clk_i);
      #1;
      if (fire) src_acc++;
      bus.s_tdata_i  = src_data[src_acc];
      bus.s_tvalid_i = (src_acc < src_limit) &&
                       (src_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
      case (snk_mode)
        0:       bus.m_tready_i = 1'b0;
        1:       bus.m_tready_i = 1'b1;
        default: bus.m_tready_i = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Monitor: scoreboard compare plus hold-while-stalled check.
  initial begin
    bit               stall_prev;
    logic [DATAW-1:0] held;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid_held", bus.m_tvalid_o, 1);
          check("stall_data_stable", bus.m_tdata_o, held);
        end
        if (bus.m_tvalid_o && bus.m_tready_i) begin
          check("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("beat_data", bus.m_tdata_o, exp_q.pop_front());
          beat_cyc.push_back(cyc);
          m_cnt++;
        end
        stall_prev = bus.m_tvalid_o && !bus.m_tready_i;
        held       = bus.m_tdata_o;
`ifdef WFG_BURST_IRQ_EN
        if (done_irq_o) irq_cnt++;
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic arm(input int len, input int gap, input int rep,
                     input bit rnd, input int snk, input int n_exp, input int supply);
    burst_len_i = CNTW'(len);
    gap_len_i   = CNTW'(gap);
    repeat_i    = 8'(rep);
    src_rand    = rnd;
    snk_mode    = snk;
    src_limit   = src_acc + supply;
    m_cnt       = 0;
    irq_cnt     = 0;
    beat_cyc.delete();
    exp_q.delete();
    for (int i = 0; i < n_exp; i++) exp_q.push_back(src_data[src_acc + i]);
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    for (int k = 0; k < budget && m_cnt < n; k++) @(posedge wb_clk_i);
    check({tag, "_beats"}, m_cnt, n);
  endtask

  // Finite burst scenario: expected stream is len*rep table samples in order.
  task automatic run_burst(input string tag, input int len, input int gap,
                           input int rep, input bit rnd, input int snk);
    int n;
    n = len * rep;
    arm(len, gap, rep, rnd, snk, n, n);
    @(posedge wb_clk_i); #1 ctrl_en_i = 1'b1;
    // Config changes after the start must be ignored.
    @(posedge wb_clk_i); #1;
    burst_len_i = CNTW'($urandom);
    gap_len_i   = CNTW'($urandom);
    repeat_i    = 8'($urandom);
    wait_beats(tag, n, 4000);
    repeat (4) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check({tag, "_burst_cnt"}, burst_cnt_o, rep);
    check({tag, "_busy_done"}, busy_o, 0);
    check({tag, "_s_tready_done"}, bus.s_tready_o, 0);
    check({tag, "_m_tvalid_done"}, bus.m_tvalid_o, 0);
    check({tag, "_no_extra_beats"}, m_cnt, n);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
`ifdef WFG_BURST_IRQ_EN
    check({tag, "_irq_pulses"}, irq_cnt, 1);
`endif
  endtask

  task automatic end_run();
    @(posedge wb_clk_i); #1 ctrl_en_i = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("idle_after_disable", busy_o, 0);
  endtask

  initial begin
    bit found;
    int base;
    for (int i = 0; i < 4096; i++) src_data[i] = DATAW'($urandom);
    wb_rst_i    = 1'b1;
    ctrl_en_i   = 1'b0;
    burst_len_i = '0;
    gap_len_i   = '0;
    repeat_i    = '0;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("rst_m_tvalid", bus.m_tvalid_o, 0);
    check("rst_m_tdata", bus.m_tdata_o, 0);
    check("rst_s_tready", bus.s_tready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_burst_cnt", burst_cnt_o, 0);

    // Single burst, contiguous delivery.
    run_burst("t1", 4, 0, 1, 1'b0, 1);
    if (beat_cyc.size() == 4) check("t1_contiguous", beat_cyc[3] - beat_cyc[0], 3);
    end_run();

    // Two bursts with a gap.
    run_burst("t2", 3, 5, 2, 1'b0, 1);
    if (beat_cyc.size() == 6) begin
      check("t2_burst_a_contiguous", beat_cyc[2] - beat_cyc[0], 2);
      check("t2_burst_b_contiguous", beat_cyc[5] - beat_cyc[3], 2);
      check("t2_gap_idle_ge_5", (beat_cyc[3] - beat_cyc[2] - 1) >= 5, 1);
    end
    end_run();

    // Backpressure on both sides.
    run_burst("t3", 8, 0, 1, 1'b1, 2);
    end_run();

    // Random configurations.
    for (int r = 0; r < 4; r++) begin
      run_burst("rnd", $urandom_range(1, 6), $urandom_range(0, 3),
                $urandom_range(1, 3), 1'b1, 2);
      end_run();
    end

    // Abort mid-burst with the last beat stalled.
    base = src_acc;
    arm(16, 0, 0, 1'b0, 1, 6, 100);
    @(posedge wb_clk_i); #1 ctrl_en_i = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge wb_clk_i);
      if (bus.s_tvalid_i && bus.s_tready_o && (src_acc == base + 5)) found = 1'b1;
    end
    check("t4_sixth_accept_seen", found, 1);
    snk_mode = 0;
    @(posedge wb_clk_i); #1 ctrl_en_i = 1'b0;
    @(negedge wb_clk_i);
    check("t4_s_tready_drop", bus.s_tready_o, 0);
    check("t4_pending_valid", bus.m_tvalid_o, 1);
    check("t4_busy_while_draining", busy_o, 1);
    check("t4_delivered_before_stall", m_cnt, 5);
    repeat (2) @(negedge wb_clk_i);
    snk_mode = 1;
    wait_beats("t4", 6, 50);
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("t4_idle", busy_o, 0);
    check("t4_burst_cnt", burst_cnt_o, 0);
    check("t4_no_extra_beats", m_cnt, 6);
    check("t4_m_tvalid", bus.m_tvalid_o, 0);
    check("t4_queue_empty", exp_q.size(), 0);
`ifdef WFG_BURST_IRQ_EN
    check("t4_no_irq", irq_cnt, 0);
`endif

    // Zero length never starts.
    arm(0, 0, 1, 1'b0, 1, 0, 50);
    @(posedge wb_clk_i); #1 ctrl_en_i = 1'b1;
    repeat (5) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("t5_len0_busy", busy_o, 0);
    check("t5_len0_s_tready", bus.s_tready_o, 0);
    check("t5_len0_m_tvalid", bus.m_tvalid_o, 0);
    @(posedge wb_clk_i); #1 ctrl_en_i = 1'b0;

    // Infinite mode, 300 one-beat bursts: count wraps to 300 mod 256.
    arm(1, 0, 0, 1'b0, 1, 300, 300);
    @(posedge wb_clk_i); #1 ctrl_en_i = 1'b1;
    wait_beats("t5_inf", 300, 3000);
    repeat (4) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("t5_inf_burst_cnt", burst_cnt_o, 300 % 256);
    check("t5_inf_still_busy", busy_o, 1);
    check("t5_inf_queue_empty", exp_q.size(), 0);
`ifdef WFG_BURST_IRQ_EN
    check("t5_inf_no_irq", irq_cnt, 0);
`endif
    @(posedge wb_clk_i); #1 ctrl_en_i = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("t5_inf_abort_idle", busy_o, 0);
    check("t5_inf_cnt_kept", burst_cnt_o, 44);

    // Reset while a beat sits in the output stage.
    arm(8, 0, 1, 1'b0, 0, 0, 8);
    @(posedge wb_clk_i); #1 ctrl_en_i = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge wb_clk_i);
      if (bus.m_tvalid_o) found = 1'b1;
    end
    check("t6_stage_full", found, 1);
    @(posedge wb_clk_i); #1;
    wb_rst_i  = 1'b1;
    ctrl_en_i = 1'b0;
    @(posedge wb_clk_i); #1 wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("t6_m_tvalid", bus.m_tvalid_o, 0);
    check("t6_m_tdata", bus.m_tdata_o, 0);
    check("t6_s_tready", bus.s_tready_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_burst_cnt", burst_cnt_o, 0);
    check("t6_discarded", m_cnt, 0);
    run_burst("t6_restart", 4, 0, 1, 1'b0, 1);
    if (beat_cyc.size() == 4) check("t6_contiguous", beat_cyc[3] - beat_cyc[0], 3);
    end_run();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
